// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the scoreboard hazard unit.
// Flush bit positions, producer latency classes and register index type.
package hazard_pkg;

    localparam int FLUSH_IF_ID = 0;
    localparam int FLUSH_ID_EX = 1;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_CSR  = 1;

    localparam int NUM_REGS_DEF = 32;

    typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SRC_OK,
        SRC_WAIT_CNT,
        SRC_WAIT_BUSY
    } src_state_e;

    // Classify one source operand against its scoreboard entry.
    function automatic src_state_e src_check(
        input logic       used,
        input logic       is_x0,
        input logic       busy,
        input logic       cnt_gt1,
        input logic       cnt_nz,
        input logic       branch
    );
        src_state_e s;
        s = SRC_OK;
        if (used && !is_x0) begin
            if (busy)
                s = SRC_WAIT_BUSY;
            else if (branch ? cnt_nz : cnt_gt1)
                s = SRC_WAIT_CNT;
        end
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side request, writeback, redirect and status bundle of the hazard unit.
// The pipeline drives through master; the scoreboard consumes through slave.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS   = 32,
    parameter int LAT_W      = 3,
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
);
    localparam int RW = $clog2(NUM_REGS);

    logic             id_valid;
    logic [RW-1:0]    id_rs1;
    logic [RW-1:0]    id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RW-1:0]    id_rd;
    logic             id_reg_write;
    logic [LAT_W-1:0] id_latency;
    logic             id_long_op;
    logic             id_is_branch;
    logic             long_wb_valid;
    logic [RW-1:0]    long_wb_rd;
    logic             ex_redirect;
    logic             id_redirect;
    logic             inst_mem_wait;
    logic             data_mem_wait;

    logic                  hazard_stall;
    logic                  mem_stall;
    logic [NUM_STAGES-1:0] flush_mask;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output id_rd, id_reg_write, id_latency, id_long_op, id_is_branch,
        output long_wb_valid, long_wb_rd, ex_redirect, id_redirect,
        output inst_mem_wait, data_mem_wait,
        input  hazard_stall, mem_stall, flush_mask, busy_vec, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  id_rd, id_reg_write, id_latency, id_long_op, id_is_branch,
        input  long_wb_valid, long_wb_rd, ex_redirect, id_redirect,
        input  inst_mem_wait, data_mem_wait,
        output hazard_stall, mem_stall, flush_mask, busy_vec, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: forwarding countdown plus long-op busy flag.
// An issue-write beats the same-cycle decrement; set beats clear on busy.
module sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hold,
    input  logic             i_wr_cnt,
    input  logic [LAT_W-1:0] i_cnt,
    input  logic             i_set_busy,
    input  logic             i_clr_busy,
    output logic [LAT_W-1:0] o_cnt,
    output logic             o_busy
);

    logic [LAT_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_wr_cnt) begin
            r_cnt <= i_cnt;
        end else if (!i_hold && r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    // Writeback is not gated by memory waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
        end else if (i_set_busy) begin
            r_busy <= 1'b1;
        end else if (i_clr_busy) begin
            r_busy <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit beside ID: per-register countdown/busy state,
// source-operand stall, redirect flush mask and saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int LAT_W      = 3,
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
) (
    input  logic clk,
    input  logic rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int RW = $clog2(NUM_REGS);

    logic [LAT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;

    logic             w_mem_stall;
    logic             w_hazard;
    logic             w_issue;
    logic             w_wr_en;
    logic [LAT_W-1:0] w_wr_val;
    logic             w_waw;
    src_state_e       w_s1;
    src_state_e       w_s2;

    logic [NUM_STAGES-1:0] w_flush;
    logic [CNT_W-1:0]      r_stall_cnt;

    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_ent
            sb_entry #(
                .LAT_W (LAT_W)
            ) u_ent (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_hold     (w_mem_stall),
                .i_wr_cnt   (w_wr_en && bus.id_rd == RW'(g)),
                .i_cnt      (w_wr_val),
                .i_set_busy (w_wr_en && bus.id_long_op &&
                             bus.id_rd == RW'(g)),
                .i_clr_busy (bus.long_wb_valid &&
                             bus.long_wb_rd == RW'(g)),
                .o_cnt      (w_cnt[g]),
                .o_busy     (w_busy[g])
            );
        end
    endgenerate

    assign w_mem_stall = bus.inst_mem_wait | bus.data_mem_wait;

    assign w_s1 = src_check(
        bus.id_rs1_used,
        bus.id_rs1 == '0,
        w_busy[bus.id_rs1],
        w_cnt[bus.id_rs1] > LAT_W'(1),
        w_cnt[bus.id_rs1] != '0,
        bus.id_is_branch
    );

    assign w_s2 = src_check(
        bus.id_rs2_used,
        bus.id_rs2 == '0,
        w_busy[bus.id_rs2],
        w_cnt[bus.id_rs2] > LAT_W'(1),
        w_cnt[bus.id_rs2] != '0,
        bus.id_is_branch
    );

    assign w_waw = bus.id_reg_write && bus.id_rd != '0 &&
                   w_busy[bus.id_rd];

    // Registered state only: a same-cycle writeback does not unstall.
    assign w_hazard = bus.id_valid &&
                      (w_s1 != SRC_OK || w_s2 != SRC_OK || w_waw);

    assign w_issue = bus.id_valid && !w_hazard &&
                     !w_mem_stall && !bus.ex_redirect;

    assign w_wr_en  = w_issue && bus.id_reg_write && bus.id_rd != '0;
    assign w_wr_val = bus.id_long_op ? '0 :
                      bus.id_latency + LAT_W'(1);

    always_comb begin
        w_flush = '0;
        if (bus.ex_redirect) begin
            w_flush[FLUSH_IF_ID] = 1'b1;
            w_flush[FLUSH_ID_EX] = 1'b1;
        end else if (bus.id_redirect && !w_hazard) begin
            w_flush[FLUSH_IF_ID] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !w_mem_stall &&
                     r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.hazard_stall = w_hazard;
    assign bus.mem_stall    = w_mem_stall;
    assign bus.flush_mask   = w_flush;
    assign bus.busy_vec     = w_busy;
    assign bus.stall_count  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random
// traffic against a timestamp-based readiness model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NR = 32;
    localparam int LW = 3;
    localparam int NS = 5;
    localparam int CW = 32;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    hazard_scoreboard_if #(
        .NUM_REGS (NR), .LAT_W (LW), .NUM_STAGES (NS), .CNT_W (CW)
    ) bus ();

    hazard_scoreboard #(
        .NUM_REGS (NR), .LAT_W (LW), .NUM_STAGES (NS), .CNT_W (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: t_m counts clock edges without a memory wait. A register is
    // forwardable-in-EX when ready_at - t_m <= 1, readable in ID at 0.
    longint ready_at [NR];
    bit     busy_m   [NR];
    longint t_m;
    longint sc_m;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            ready_at[i] = 0;
            busy_m[i]   = 0;
        end
        t_m  = 0;
        sc_m = 0;
    endtask

    function automatic bit src_haz(int s, bit br);
        longint rem;
        if (s == 0) return 1'b0;
        rem = ready_at[s] - t_m;
        if (rem < 0) rem = 0;
        return busy_m[s] || (br ? (rem >= 1) : (rem > 1));
    endfunction

    function automatic bit exp_stall();
        bit h;
        h = 0;
        if (bus.id_rs1_used && src_haz(int'(bus.id_rs1), bus.id_is_branch))
            h = 1;
        if (bus.id_rs2_used && src_haz(int'(bus.id_rs2), bus.id_is_branch))
            h = 1;
        if (bus.id_reg_write && bus.id_rd != 0 && busy_m[bus.id_rd])
            h = 1;
        return bus.id_valid && h;
    endfunction

    function automatic logic [NS-1:0] exp_flush();
        if (bus.ex_redirect) return 5'b00011;
        if (bus.id_redirect && !exp_stall()) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic logic [NR-1:0] exp_busy();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = busy_m[i];
        return v;
    endfunction

    task automatic model_step();
        bit ms, st, iss;
        ms  = bus.inst_mem_wait || bus.data_mem_wait;
        st  = exp_stall();
        iss = bus.id_valid && !st && !ms && !bus.ex_redirect;
        if (bus.long_wb_valid && bus.long_wb_rd != 0)
            busy_m[bus.long_wb_rd] = 0;
        if (iss && bus.id_reg_write && bus.id_rd != 0) begin
            if (bus.id_long_op) begin
                busy_m[bus.id_rd]   = 1;
                ready_at[bus.id_rd] = t_m;
            end else begin
                ready_at[bus.id_rd] = t_m + longint'(bus.id_latency) + 2;
            end
        end
        if (st && !ms && sc_m < 64'hFFFF_FFFF) sc_m++;
        if (!ms) t_m++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid      = 0;
        bus.id_rs1        = '0;
        bus.id_rs2        = '0;
        bus.id_rs1_used   = 0;
        bus.id_rs2_used   = 0;
        bus.id_rd         = '0;
        bus.id_reg_write  = 0;
        bus.id_latency    = '0;
        bus.id_long_op    = 0;
        bus.id_is_branch  = 0;
        bus.long_wb_valid = 0;
        bus.long_wb_rd    = '0;
        bus.ex_redirect   = 0;
        bus.id_redirect   = 0;
        bus.inst_mem_wait = 0;
        bus.data_mem_wait = 0;
    endtask

    task automatic set_id(input reg_idx_t rs1, input bit u1,
                          input reg_idx_t rs2, input bit u2,
                          input reg_idx_t rd, input bit wr,
                          input int lat, input bit lng, input bit br);
        bus.id_valid     = 1;
        bus.id_rs1       = rs1;
        bus.id_rs1_used  = u1;
        bus.id_rs2       = rs2;
        bus.id_rs2_used  = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = wr;
        bus.id_latency   = LW'(lat);
        bus.id_long_op   = lng;
        bus.id_is_branch = br;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0 || bus.mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b/%b want 0/0",
                     bus.hazard_stall, bus.mem_stall);
        end
        checks++;
        if (bus.flush_mask !== 5'b0 || bus.stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_flush_cnt: got %b/%0d want 0/0",
                     bus.flush_mask, bus.stall_count);
        end
        checks++;
        if (bus.busy_vec !== 32'd0) begin
            errors++;
            $display("FAIL reset_busy: got %h want 0", bus.busy_vec);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load_use();
        set_id(0, 0, 0, 0, 5, 1, LAT_LOAD, 0, 0);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_issue: got %b want 0", bus.hazard_stall);
        end
        tick();
        set_id(5, 1, 1, 1, 6, 1, LAT_ALU, 0, 0);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b want 1", bus.hazard_stall);
        end
        tick();
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: got %b want 0", bus.hazard_stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.stall_count !== 32'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d want 1", bus.stall_count);
        end
    endtask

    task automatic test_branch();
        int n;
        set_id(0, 0, 0, 0, 7, 1, LAT_ALU, 0, 0);
        tick();
        set_id(7, 1, 0, 1, 0, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!bus.hazard_stall) break;
            n++;
            tick();
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL alu_branch_stalls: got %0d want 1", n);
        end
        tick();
        set_id(0, 0, 0, 0, 8, 1, LAT_LOAD, 0, 0);
        tick();
        set_id(8, 1, 0, 1, 0, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!bus.hazard_stall) break;
            n++;
            tick();
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL load_branch_stalls: got %0d want 2", n);
        end
        tick();
        idle();
    endtask

    task automatic test_long_op();
        set_id(0, 0, 0, 0, 9, 1, 0, 1, 0);
        tick();
        set_id(9, 1, 2, 1, 10, 1, LAT_ALU, 0, 0);
        #1;
        checks++;
        if (bus.busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL long_busy_set: got %b want 1", bus.busy_vec[9]);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.hazard_stall !== 1'b1) begin
                errors++;
                $display("FAIL long_hold_%0d: got %b want 1",
                         i, bus.hazard_stall);
            end
            tick();
        end
        bus.long_wb_valid = 1;
        bus.long_wb_rd    = 9;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL long_wb_same_cycle: got %b want 1", bus.hazard_stall);
        end
        tick();
        bus.long_wb_valid = 0;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0 || bus.busy_vec[9] !== 1'b0) begin
            errors++;
            $display("FAIL long_release: got %b/%b want 0/0",
                     bus.hazard_stall, bus.busy_vec[9]);
        end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        set_id(0, 0, 0, 0, 11, 1, LAT_LOAD, 0, 0);
        tick();
        set_id(11, 1, 0, 0, 12, 1, LAT_ALU, 0, 0);
        bus.data_mem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.mem_stall !== 1'b1 || bus.hazard_stall !== 1'b1 ||
                bus.stall_count !== sc_m[CW-1:0]) begin
                errors++;
                $display("FAIL mem_wait_%0d: got %b/%b/%0d want 1/1/%0d",
                         i, bus.mem_stall, bus.hazard_stall,
                         bus.stall_count, sc_m);
            end
            tick();
        end
        bus.data_mem_wait = 0;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1 || bus.mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_after: got %b/%b want 1/0",
                     bus.hazard_stall, bus.mem_stall);
        end
        tick();
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_release: got %b want 0", bus.hazard_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_redirect();
        set_id(0, 0, 0, 0, 12, 1, LAT_ALU, 0, 0);
        bus.ex_redirect = 1;
        #1;
        checks++;
        if (bus.flush_mask !== 5'b00011) begin
            errors++;
            $display("FAIL ex_redirect_flush: got %b want 00011", bus.flush_mask);
        end
        tick();
        bus.ex_redirect = 0;
        set_id(12, 1, 0, 0, 0, 0, 0, 0, 1);
        bus.id_redirect = 1;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0 || bus.flush_mask !== 5'b00001) begin
            errors++;
            $display("FAIL squash_no_mark: got %b/%b want 0/00001",
                     bus.hazard_stall, bus.flush_mask);
        end
        tick();
        bus.id_redirect = 0;
        set_id(0, 0, 0, 0, 13, 1, LAT_LOAD, 0, 0);
        tick();
        set_id(13, 1, 0, 0, 0, 0, 0, 0, 1);
        bus.id_redirect = 1;
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1 || bus.flush_mask !== 5'b00000) begin
            errors++;
            $display("FAIL id_redirect_stalled: got %b/%b want 1/00000",
                     bus.hazard_stall, bus.flush_mask);
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        set_id(0, 0, 0, 0, 9, 1, 0, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 5, 1, LAT_LOAD, 0, 0);
        tick();
        set_id(5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b1 || bus.busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: got %b/%b want 1/1",
                     bus.hazard_stall, bus.busy_vec[9]);
        end
        #1;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (bus.hazard_stall !== 1'b0 || bus.busy_vec !== 32'd0 ||
            bus.stall_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: got %b/%h/%0d want 0/0/0",
                     bus.hazard_stall, bus.busy_vec, bus.stall_count);
        end
        @(negedge clk);
        rst_n = 1;
        set_id(0, 0, 0, 0, 0, 1, 0, 1, 0);
        bus.long_wb_valid = 1;
        bus.long_wb_rd    = 0;
        tick();
        bus.long_wb_valid = 0;
        set_id(0, 1, 9, 1, 0, 1, 0, 0, 1);
        #1;
        checks++;
        if (bus.busy_vec !== 32'd0 || bus.hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_ignored: got %h/%b want 0/0",
                     bus.busy_vec, bus.hazard_stall);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            bus.id_valid     = ($urandom_range(0, 9) != 0);
            bus.id_rs1       = reg_idx_t'($urandom_range(0, 15));
            bus.id_rs2       = reg_idx_t'($urandom_range(0, 15));
            bus.id_rs1_used  = $urandom_range(0, 1);
            bus.id_rs2_used  = $urandom_range(0, 1);
            bus.id_rd        = reg_idx_t'($urandom_range(0, 15));
            bus.id_reg_write = ($urandom_range(0, 3) != 0);
            bus.id_latency   = LW'($urandom_range(0, 6));
            bus.id_long_op   = ($urandom_range(0, 15) == 0);
            bus.id_is_branch = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.long_wb_valid = 1;
                bus.long_wb_rd    = reg_idx_t'($urandom_range(0, 15));
                for (int k = 0; k < 8; k++) begin
                    int r;
                    r = $urandom_range(1, 15);
                    if (busy_m[r]) begin
                        bus.long_wb_rd = reg_idx_t'(r);
                        break;
                    end
                end
            end
            bus.ex_redirect   = ($urandom_range(0, 11) == 0);
            bus.id_redirect   = ($urandom_range(0, 7) == 0);
            bus.inst_mem_wait = ($urandom_range(0, 9) == 0);
            bus.data_mem_wait = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (bus.hazard_stall !== exp_stall() ||
                bus.mem_stall !== (bus.inst_mem_wait | bus.data_mem_wait)) begin
                errors++;
                $display("FAIL rnd_stall c=%0d: got %b/%b want %b",
                         c, bus.hazard_stall, bus.mem_stall, exp_stall());
            end
            checks++;
            if (bus.flush_mask !== exp_flush() ||
                bus.busy_vec !== exp_busy() ||
                bus.stall_count !== sc_m[CW-1:0]) begin
                errors++;
                $display("FAIL rnd_state c=%0d: got %b/%h/%0d want %b/%h/%0d",
                         c, bus.flush_mask, bus.busy_vec, bus.stall_count,
                         exp_flush(), exp_busy(), sc_m);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_long_op();
        test_mem_wait();
        test_redirect();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard-based hazard unit for the in-order pipeline, replacing fixed producer/consumer comparisons with per-register countdown state. It sits beside the ID stage and records every register-writing instruction as it issues, including unbounded-latency ops (divider) that retire out of band. It raises `hazard_stall` while any source operand is not yet forwardable, and merges redirect and memory-wait inputs into `flush_mask`/`mem_stall`. It also keeps a saturating stall-cycle performance counter.

## Interface
- `NUM_REGS`, 32: architectural registers; x0 is never tracked.
- `LAT_W`, 3: countdown width; `id_latency` max is 2**LAT_W-2.
- `NUM_STAGES`, 5: `flush_mask` width; bit0 = IF/ID, bit1 = ID/EX.
- `CNT_W`, 32: stall counter width.
- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in $clog2(NUM_REGS) each: sources.
- `id_rs1_used`, `id_rs2_used` in 1 each: source is actually read.
- `id_rd` in $clog2(NUM_REGS): destination.
- `id_reg_write` in 1: writes `id_rd`.
- `id_latency` in LAT_W: extra cycles after EX before result is forwardable (ALU 0, load/CSR 1).
- `id_long_op` in 1: unbounded-latency writer; completion via `long_wb_*`.
- `id_is_branch` in 1: operands are consumed in ID, one stage early.
- `long_wb_valid` in 1, `long_wb_rd` in $clog2(NUM_REGS): long-op result written back.
- `ex_redirect` in 1: JAL/JALR mispredict resolved in EX.
- `id_redirect` in 1: branch redirect resolved in ID.
- `inst_mem_wait`, `data_mem_wait` in 1 each.
- `hazard_stall` out 1; `mem_stall` out 1; `flush_mask` out NUM_STAGES.
- `busy_vec` out NUM_REGS: long-op busy bits, for debug.
- `stall_count` out CNT_W.

## Operation
- State per register r≠0: countdown `cnt[r]` (LAT_W bits) and `busy[r]` (1 bit).
- `mem_stall` = `inst_mem_wait` | `data_mem_wait`.
- `issue` = `id_valid` & !`hazard_stall` & !`mem_stall` & !`ex_redirect`.
- Per-source hazard, for a used source s≠0:
  - `busy[s]` is set, or
  - `cnt[s]` > 1 for a non-branch consumer, or
  - `cnt[s]` ≥ 1 for a branch consumer.
- WAW hazard: `id_reg_write` & `id_rd`≠0 & `busy[id_rd]`.
- `hazard_stall` = `id_valid` & (any source hazard | WAW hazard). It is evaluated from registered state only; a writeback in the same cycle does not clear the stall until the next cycle.
- On `issue` with `id_reg_write` & `id_rd`≠0:
  - Long op: set `busy[rd]`; write `cnt[rd]` = 0.
  - Otherwise: write `cnt[rd]` = `id_latency`+1. This overwrites any older value; in-order issue makes the newer producer authoritative.
- Countdown: each cycle with !`mem_stall`, every nonzero cnt decrements, saturating at 0. All cnt hold while `mem_stall`.
- Long-op writeback: `long_wb_valid` & `long_wb_rd`≠0 clears `busy[long_wb_rd]`. This is honoured even during `mem_stall`.
- Precedence: a decrement and an issue-write on the same entry → the issue-write wins.
- `flush_mask`:
  - `ex_redirect` → bits[1:0] set.
  - Else `id_redirect` & !`hazard_stall` → bit0 set.
  - Else 0.
  - Upper bits are always 0.
- `stall_count`: +1 each cycle with `hazard_stall` & !`mem_stall`; saturates at all-ones.

## Timing
- Reset (async assert, sync release): all cnt=0, busy=0, `stall_count`=0. With idle inputs, `hazard_stall`=`mem_stall`=0 and `flush_mask`=0.
- Reset mid-operation clears all pending state.
- Outputs `hazard_stall`, `mem_stall`, `flush_mask` are combinational from inputs and registered state, with zero latency.
- Scoreboard updates are visible the cycle after issue.
- Stall cycles seen by a consumer directly behind its producer:
  - ALU → ALU: 0; ALU → branch: 1.
  - Load/CSR → use: 1; load → branch: 2.
  - Latency L producer → use: L; latency L producer → branch: L+1.
- An instruction squashed by `ex_redirect` never marks the scoreboard.

## Structure
- Shared package `hazard_pkg`: flush bit indices (`FLUSH_IF_ID`=0, `FLUSH_ID_EX`=1), the latency encodings (ALU=0, LOAD=1, CSR=1), and the `reg_idx_t` typedef.
- Sub-module `sb_entry`: one register's countdown and busy bit, with its set/clear/decrement logic. It is instantiated NUM_REGS-1 times via generate.
- Top level: source lookup mux, stall and flush logic, and the performance counter.

## Test plan
- Load x5 (L=1), then `add x6,x5,x1` → `hazard_stall` 1 cycle, add issues next cycle; `stall_count`=1.
- ALU x7, then `beq x7,x0` → 1 stall. Load x8, then `beq x8,x0` → 2 stalls.
- Long op x9, `sub x10,x9,x2` held; `long_wb_valid`/rd=9 at cycle 6 → stall drops at cycle 7. `busy_vec[9]` pulses then clears.
- Load x11 issued, `data_mem_wait` for 3 cycles → cnt frozen, `stall_count` unchanged, use of x11 still stalls exactly 1 non-wait cycle.
- `ex_redirect` while ID holds write to x12 → `flush_mask`=00011, x12 never marked. `id_redirect` with `hazard_stall`=1 → `flush_mask`=0.
- Reset asserted with cnt[5]=2 and busy[9]=1 → all cleared immediately; rd=0 writes and `long_wb_rd`=0 are ignored.
